// File: rtl/instruction_sequencer_if.sv
// Handshake and status bundle between the instruction sequencer and its
// decode/memory environment.
interface instruction_sequencer_if;
  logic        branchFlag;
  logic        unconditionalBranchFlag;
  logic        zeroFlag;
  logic [31:0] pcOffsetFilled;
  logic        isLoad;
  logic        isStore;
  logic        regWriteEn;
  logic        imemReady;
  logic        dmemReady;
  logic        halt;
  logic [31:0] PC;
  logic        fetchReq;
  logic        irWrite;
  logic        regWrite;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  state;
  logic [31:0] retired;
  logic        timeout;

  modport master (
    input  branchFlag, unconditionalBranchFlag, zeroFlag, pcOffsetFilled,
           isLoad, isStore, regWriteEn, imemReady, dmemReady, halt,
    output PC, fetchReq, irWrite, regWrite, memRead, memWrite, state,
           retired, timeout
  );

  modport slave (
    output branchFlag, unconditionalBranchFlag, zeroFlag, pcOffsetFilled,
           isLoad, isStore, regWriteEn, imemReady, dmemReady, halt,
    input  PC, fetchReq, irWrite, regWrite, memRead, memWrite, state,
           retired, timeout
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Multi-cycle instruction sequencer: steps fetch/decode/execute/memory/writeback,
// owns the PC, counts retired instructions and flags memory-wait timeouts.
//
//   state     | meaning
//   FETCH     | request instruction, wait for imemReady
//   DECODE    | one-cycle decode slot
//   EXECUTE   | latch branch decision, target and memory op
//   MEMORY    | hold memRead/memWrite until dmemReady
//   WRITEBACK | regWrite strobe, PC update, retire
//   HALTED    | idle until reset
module instruction_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input logic                      clock,
  input logic                      reset,
  instruction_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALTED    = 3'd5
  } state_t;

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  state_t        stateQ;
  logic [31:0]   pcQ;
  logic [31:0]   retiredQ;
  logic [31:0]   targetQ;
  logic          takeBranchQ;
  logic          loadQ;
  logic          storeQ;
  logic          timeoutQ;
  logic [WW-1:0] waitQ;
  logic          waiting;

  assign waiting = ((stateQ == FETCH)  && !bus.imemReady) ||
                   ((stateQ == MEMORY) && !bus.dmemReady);

  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ      <= FETCH;
      pcQ         <= RESET_PC;
      retiredQ    <= '0;
      targetQ     <= '0;
      takeBranchQ <= 1'b0;
      loadQ       <= 1'b0;
      storeQ      <= 1'b0;
      timeoutQ    <= 1'b0;
      waitQ       <= '0;
    end else begin
      // Counter saturates so the sticky flag cannot re-arm on wrap.
      if (waiting) begin
        if (waitQ != WAIT_MAX) waitQ <= waitQ + 1'b1;
        if (waitQ == WAIT_LAST) timeoutQ <= 1'b1;
      end else begin
        waitQ <= '0;
      end

      case (stateQ)
        FETCH:     if (bus.imemReady) stateQ <= DECODE;
        DECODE:    stateQ <= EXECUTE;
        EXECUTE: begin
          takeBranchQ <= (bus.zeroFlag & bus.branchFlag) | bus.unconditionalBranchFlag;
          targetQ     <= pcQ + (bus.pcOffsetFilled << 2);
          loadQ       <= bus.isLoad;
          storeQ      <= bus.isStore & ~bus.isLoad;
          stateQ      <= (bus.isLoad | bus.isStore) ? MEMORY : WRITEBACK;
        end
        MEMORY:    if (bus.dmemReady) stateQ <= WRITEBACK;
        WRITEBACK: begin
          pcQ      <= takeBranchQ ? targetQ : pcQ + 32'd4;
          retiredQ <= retiredQ + 32'd1;
          stateQ   <= bus.halt ? HALTED : FETCH;
        end
        HALTED:    stateQ <= HALTED;
        default:   stateQ <= FETCH;
      endcase
    end
  end

  // Write strobes are suppressed while reset is sampled so an aborted
  // instruction leaves no architectural side effect.
  assign bus.fetchReq = (stateQ == FETCH);
  assign bus.irWrite  = (stateQ == FETCH) && bus.imemReady && !reset;
  assign bus.memRead  = (stateQ == MEMORY) && loadQ;
  assign bus.memWrite = (stateQ == MEMORY) && storeQ;
  assign bus.regWrite = (stateQ == WRITEBACK) && bus.regWriteEn && !reset;
  assign bus.PC       = pcQ;
  assign bus.state    = stateQ;
  assign bus.retired  = retiredQ;
  assign bus.timeout  = timeoutQ;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: vector table with a PC model
// and scoreboard, plus hand-written timeout, halt and mid-instruction reset cases.
module tb_instruction_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  instruction_sequencer_if bus ();

  instruction_sequencer #(.RESET_PC(32'h0000_0000), .MAX_WAIT(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        br, ub, zf;
    logic [31:0] off;
    logic        ld, st, rwe, hlt;
    int          memDelay;
    int          expCycles, expRw, expMr, expMw;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ret;
    logic [2:0]  st;
    int          cycles, rw, mr, mw;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sbq[$];
  logic [31:0] modelPc;
  logic [31:0] modelRet;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic br, input logic ub, input logic zf,
                              input logic [31:0] off, input logic ld, input logic st,
                              input logic rwe, input int md, input int cyc,
                              input int rw, input int mr, input int mw);
    vec_t v;
    v.br = br; v.ub = ub; v.zf = zf; v.off = off;
    v.ld = ld; v.st = st; v.rwe = rwe; v.hlt = 1'b0;
    v.memDelay = md; v.expCycles = cyc; v.expRw = rw; v.expMr = mr; v.expMw = mw;
    return v;
  endfunction

  task automatic clearInputs();
    bus.branchFlag = 0; bus.unconditionalBranchFlag = 0; bus.zeroFlag = 0;
    bus.pcOffsetFilled = '0; bus.isLoad = 0; bus.isStore = 0; bus.regWriteEn = 0;
    bus.imemReady = 0; bus.dmemReady = 0; bus.halt = 0;
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic doReset();
    reset = 1'b1;
    clearInputs();
    @(negedge clock);
    reset = 1'b0;
    modelPc = 32'h0;
    modelRet = 32'h0;
  endtask

  // Called at a negedge with the DUT in FETCH; returns at the negedge after writeback.
  task automatic runInstr(input vec_t v);
    exp_t e, got;
    logic taken;
    int   memCycles, irw;
    bit   done, bothHigh;
    taken  = (v.zf & v.br) | v.ub;
    e.pc   = taken ? modelPc + (v.off << 2) : modelPc + 32'd4;
    e.ret  = modelRet + 32'd1;
    e.st   = v.hlt ? 3'd5 : 3'd0;
    e.cycles = v.expCycles; e.rw = v.expRw; e.mr = v.expMr; e.mw = v.expMw;
    sbq.push_back(e);

    bus.branchFlag = v.br; bus.unconditionalBranchFlag = v.ub; bus.zeroFlag = v.zf;
    bus.pcOffsetFilled = v.off; bus.isLoad = v.ld; bus.isStore = v.st;
    bus.regWriteEn = v.rwe; bus.halt = v.hlt; bus.imemReady = 1'b1; bus.dmemReady = 1'b0;

    got.cycles = 0; got.rw = 0; got.mr = 0; got.mw = 0;
    memCycles = 0; irw = 0; done = 0; bothHigh = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (bus.state == 3'd3) begin
        bus.dmemReady = (memCycles >= v.memDelay);
        memCycles++;
      end else begin
        bus.dmemReady = 1'b0;
      end
      if (bus.state == 3'd4) done = 1;
      #1;
      got.cycles++;
      if (bus.regWrite) got.rw++;
      if (bus.memRead)  got.mr++;
      if (bus.memWrite) got.mw++;
      if (bus.irWrite)  irw++;
      if (bus.memRead && bus.memWrite) bothHigh = 1;
      @(negedge clock);
    end
    check("instr_completes_in_bound", 32'(done), 32'd1);
    bus.dmemReady = 1'b0;
    bus.halt = 1'b0;
    got.pc = bus.PC; got.ret = bus.retired; got.st = bus.state;

    e = sbq.pop_front();
    check("pc_after_wb", got.pc, e.pc);
    check("retired", got.ret, e.ret);
    check("state_after_wb", 32'(got.st), 32'(e.st));
    check("instr_cycles", got.cycles, e.cycles);
    check("regWrite_pulses", got.rw, e.rw);
    check("memRead_cycles", got.mr, e.mr);
    check("memWrite_cycles", got.mw, e.mw);
    check("irWrite_pulses", irw, 1);
    check("mem_never_both", 32'(bothHigh), 32'd0);
    modelPc = e.pc;
    modelRet = e.ret;
  endtask

  initial begin
    vec_t v;
    clearInputs();
    modelPc = 0;
    modelRet = 0;

    // br ub zf off            ld st rwe md cyc rw mr mw
    tbl.push_back(mk(0,0,0,32'h0,        0,0,1, 0, 4,1,0,0));
    tbl.push_back(mk(0,0,0,32'h0,        0,0,1, 0, 4,1,0,0));
    tbl.push_back(mk(0,0,0,32'h0,        0,0,0, 0, 4,0,0,0));
    tbl.push_back(mk(1,0,1,32'h4,        0,0,1, 0, 4,1,0,0));
    tbl.push_back(mk(1,0,0,32'h4,        0,0,1, 0, 4,1,0,0));
    tbl.push_back(mk(0,0,1,32'h4,        0,0,1, 0, 4,1,0,0));
    tbl.push_back(mk(0,1,0,32'hFFFFFFFE, 0,0,1, 0, 4,1,0,0));
    tbl.push_back(mk(0,0,0,32'h0,        1,0,1, 0, 5,1,1,0));
    tbl.push_back(mk(0,0,0,32'h0,        0,1,0, 3, 8,0,0,4));
    tbl.push_back(mk(0,0,0,32'h0,        1,1,1, 1, 6,1,2,0));
    tbl.push_back(mk(1,0,1,32'h2,        1,0,1, 0, 5,1,1,0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,0,32'h0, 0,0,1, 0, 4,1,0,0));
    tbl.push_back(mk(1,0,1,32'hFFFFFFFE, 0,0,1, 0, 4,1,0,0));
    tbl.push_back(mk(0,1,0,32'h2,        0,0,1, 0, 4,1,0,0));
    tbl.push_back(mk(1,0,0,32'hFFFFFFFE, 0,0,1, 0, 4,1,0,0));
    tbl.push_back(mk(0,1,0,32'h3FFFFFEE, 0,0,1, 0, 4,1,0,0));
    tbl.push_back(mk(0,1,0,32'h3,        0,0,1, 0, 4,1,0,0));

    @(negedge clock);
    doReset();
    check("rst_pc", bus.PC, 32'h0);
    check("rst_retired", bus.retired, 32'h0);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);
    check("rst_fetchReq", 32'(bus.fetchReq), 32'd1);
    check("rst_memRead", 32'(bus.memRead), 32'd0);
    check("rst_memWrite", 32'(bus.memWrite), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      runInstr(tbl[i]);
      if (i == 2) check("retired_after_3", bus.retired, 32'd3);
      if (i == 15) check("branch_back_pc", bus.PC, 32'h38);
      if (i == 17) check("branch_not_taken_pc", bus.PC, 32'h44);
    end
    check("wrap_pc", bus.PC, 32'h8);
    check("table_retired", bus.retired, 32'd20);

    // Fetch-wait timeout boundary and stickiness
    doReset();
    bus.imemReady = 1'b0;
    repeat (14) @(negedge clock);
    check("timeout_before_max", 32'(bus.timeout), 32'd0);
    check("wait_holds_fetch", 32'(bus.state), 32'd0);
    check("wait_no_irWrite", 32'(bus.irWrite), 32'd0);
    repeat (2) @(negedge clock);
    check("timeout_set", 32'(bus.timeout), 32'd1);
    check("wait_pc_held", bus.PC, 32'h0);
    runInstr(tbl[0]);
    check("timeout_sticky", 32'(bus.timeout), 32'd1);
    doReset();
    check("timeout_cleared", 32'(bus.timeout), 32'd0);

    // Halt freezes the updated PC
    v = tbl[0];
    v.hlt = 1'b1;
    runInstr(v);
    bus.imemReady = 1'b1;
    repeat (5) @(negedge clock);
    check("halt_state", 32'(bus.state), 32'd5);
    check("halt_pc", bus.PC, 32'h4);
    check("halt_retired", bus.retired, 32'd1);
    check("halt_fetchReq", 32'(bus.fetchReq), 32'd0);
    check("halt_regWrite", 32'(bus.regWrite), 32'd0);
    doReset();
    check("halt_exit_state", 32'(bus.state), 32'd0);

    // Reset during MEMORY with a store request active
    runInstr(tbl[0]);
    bus.isStore = 1'b1; bus.imemReady = 1'b1; bus.dmemReady = 1'b0; bus.regWriteEn = 1'b1;
    for (int c = 0; c < 10 && bus.state != 3'd3; c++) @(negedge clock);
    check("mem_reached", 32'(bus.state), 32'd3);
    check("mem_store_req", 32'(bus.memWrite), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    clearInputs();
    check("memrst_pc", bus.PC, 32'h0);
    check("memrst_retired", bus.retired, 32'd0);
    check("memrst_state", 32'(bus.state), 32'd0);
    check("memrst_memWrite", 32'(bus.memWrite), 32'd0);
    modelPc = 0; modelRet = 0;

    // Reset sampled in WRITEBACK beats the PC update and retire
    runInstr(tbl[0]);
    bus.imemReady = 1'b1; bus.regWriteEn = 1'b1;
    for (int c = 0; c < 10 && bus.state != 3'd4; c++) @(negedge clock);
    check("wb_reached", 32'(bus.state), 32'd4);
    reset = 1'b1;
    #1;
    check("wbrst_no_regWrite", 32'(bus.regWrite), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    clearInputs();
    check("wbrst_pc", bus.PC, 32'h0);
    check("wbrst_retired", bus.retired, 32'd0);
    check("wbrst_state", 32'(bus.state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

endmodule
